sm83_idu_seq: RTL and testbench

- Parametrised, clocked successor to the single-bit IDU cell: a WIDTH-bit increment/decrement/pass unit.
- Sequences the precharge/evaluate discipline explicitly as a small FSM.
- Flags a zero result and a carry/borrow out.
- Drives the result onto two independently enabled output buses (A and B). Sits between the register file and the address bus in the SM83 core.

---
 rtl/sm83_idu_seq_if.sv | 31 +++
 rtl/sm83_idu_seq.sv | 111 +++++++++++
 tb/tb_sm83_idu_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sm83_idu_seq_if.sv
// Request/result and dual output-bus bundle for the sequenced SM83 IDU.
interface sm83_idu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic             bus_a_en;
    logic             bus_b_en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             bus_a_oe;
    logic [WIDTH-1:0] bus_a_y;
    logic             bus_b_oe;
    logic [WIDTH-1:0] bus_b_y;

    modport master (
        output start, op, din, bus_a_en, bus_b_en,
        input  busy, done, result, carry, zero,
        input  bus_a_oe, bus_a_y, bus_b_oe, bus_b_y
    );

    modport slave (
        input  start, op, din, bus_a_en, bus_b_en,
        output busy, done, result, carry, zero,
        output bus_a_oe, bus_a_y, bus_b_oe, bus_b_y
    );
endinterface

// File: rtl/sm83_idu_seq.sv
// WIDTH-bit increment/decrement/pass unit sequenced as precharge/evaluate,
// with zero and carry/borrow flags and two independently enabled result buses.
module sm83_idu_seq #(
    parameter int WIDTH    = 16,
    parameter bit HOLD_BUS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    sm83_idu_seq_if.slave  io
);
    typedef enum logic [1:0] {IDLE, PCH, EVAL, DONE} state_t;

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] din_reg;
    logic [WIDTH-1:0] eval_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             have_result_reg;

    logic [WIDTH-1:0] calc_next;
    logic             carry_next;
    logic [WIDTH-1:0] result_next;

    always_comb begin
        calc_next  = '0;
        carry_next = 1'b0;
        case (op_reg)
            2'b00:   calc_next = din_reg;
            2'b01:   {carry_next, calc_next} = {1'b0, din_reg} + {{WIDTH{1'b0}}, 1'b1};
            // Borrow shows up as the extra top bit going high only for 0 - 1.
            2'b10:   {carry_next, calc_next} = {1'b0, din_reg} - {{WIDTH{1'b0}}, 1'b1};
            default: calc_next = '0;
        endcase
    end

    // The precharged node gates the evaluation, mirroring the dynamic cell.
    assign result_next = calc_next & eval_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_reg          <= 2'b00;
            din_reg         <= '0;
            eval_reg        <= '0;
            result_reg      <= '0;
            carry_reg       <= 1'b0;
            zero_reg        <= 1'b0;
            have_result_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (io.start) begin
                        op_reg    <= io.op;
                        din_reg   <= io.din;
                        state_reg <= PCH;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                PCH: begin
                    eval_reg  <= '1;
                    state_reg <= EVAL;
                end
                EVAL: begin
                    result_reg      <= result_next;
                    carry_reg       <= carry_next;
                    zero_reg        <= (result_next == '0);
                    have_result_reg <= 1'b1;
                    state_reg       <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io.busy   = (state_reg == PCH) || (state_reg == EVAL);
    assign io.done   = (state_reg == DONE);
    assign io.result = result_reg;
    assign io.carry  = carry_reg;
    assign io.zero   = zero_reg;

    logic drive_window;

    generate
        if (HOLD_BUS) begin : g_hold
            assign drive_window = ((state_reg == DONE) || (state_reg == IDLE)) && have_result_reg;
        end else begin : g_pulse
            assign drive_window = (state_reg == DONE);
        end
    endgenerate

    logic [1:0]       bus_en;
    logic [1:0]       bus_oe;
    logic [WIDTH-1:0] bus_y [2];

    assign bus_en = {io.bus_b_en, io.bus_a_en};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bus
            assign bus_oe[gi] = bus_en[gi] & drive_window;
            assign bus_y[gi]  = bus_oe[gi] ? result_reg : '0;
        end
    endgenerate

    assign io.bus_a_oe = bus_oe[0];
    assign io.bus_a_y  = bus_y[0];
    assign io.bus_b_oe = bus_oe[1];
    assign io.bus_b_y  = bus_y[1];
endmodule

// File: tb/tb_sm83_idu_seq.sv
// Bench for sm83_idu_seq: one held-bus and one pulsed-bus instance driven in parallel.
module tb_sm83_idu_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] din;
    logic        en_a;
    logic        en_b;

    int total = 0;
    int bad   = 0;

    sm83_idu_seq_if #(.WIDTH(16)) io_h ();
    sm83_idu_seq_if #(.WIDTH(16)) io_n ();

    assign io_h.start    = start;
    assign io_h.op       = op;
    assign io_h.din      = din;
    assign io_h.bus_a_en = en_a;
    assign io_h.bus_b_en = en_b;
    assign io_n.start    = start;
    assign io_n.op       = op;
    assign io_n.din      = din;
    assign io_n.bus_a_en = en_a;
    assign io_n.bus_b_en = en_b;

    sm83_idu_seq #(.WIDTH(16), .HOLD_BUS(1'b1)) dut_h (.clk(clk), .reset(reset), .io(io_h));
    sm83_idu_seq #(.WIDTH(16), .HOLD_BUS(1'b0)) dut_n (.clk(clk), .reset(reset), .io(io_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (!reset && io_h.done) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_result", io_h.result, mon_e.res);
                chk("sb_carry", io_h.carry, mon_e.c);
                chk("sb_zero", io_h.zero, mon_e.z);
                chk("sb_nohold_result", io_n.result, mon_e.res);
                chk("sb_nohold_done", io_n.done, 1);
            end
            $display("txn: result=%04h carry=%0b zero=%0b", io_h.result, io_h.carry, io_h.zero);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [15:0] d,
                         input logic [15:0] er, input logic ec, input logic ez);
        int n;
        int busy_n;
        int oe_n;
        sb_q.push_back('{res: er, c: ec, z: ez});
        op    = o;
        din   = d;
        start = 1'b1;
        n = 0;
        busy_n = 0;
        oe_n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (io_h.busy) begin
                busy_n++;
                chk("hold_oe_dropped_busy", {io_h.bus_a_oe, io_h.bus_b_oe}, 0);
            end
            if (io_n.bus_a_oe) oe_n++;
        end while (!io_h.done && n < 10);
        chk("latency", n, 3);
        chk("busy_cycles", busy_n, 2);
        chk("hold_bus_a_done", io_h.bus_a_y, er);
        chk("hold_bus_b_done", io_h.bus_b_y, en_b ? er : 16'h0000);
        chk("nohold_bus_a_done", io_n.bus_a_y, er);
        @(negedge clk);
        if (io_n.bus_a_oe) oe_n++;
        chk("nohold_oe_cycles", oe_n, 1);
        chk("nohold_bus_a_idle", io_n.bus_a_y, 0);
        chk("hold_bus_a_idle", io_h.bus_a_y, er);
        chk("idle_result_hold", io_h.result, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, expected finish earlier");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 16'h00FF, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 16'hABCD, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 16'h8000, 16'h7FFF, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        din   = 16'h0000;
        en_a  = 1'b1;
        en_b  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", io_h.result, 0);
        chk("rst_flags", {io_h.carry, io_h.zero, io_h.busy, io_h.done}, 0);
        chk("rst_hold_oe", {io_h.bus_a_oe, io_h.bus_b_oe}, 0);
        chk("rst_hold_y", {io_h.bus_a_y, io_h.bus_b_y}, 0);
        chk("rst_nohold_oe", {io_n.bus_a_oe, io_n.bus_b_oe}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_result_oe", io_h.bus_a_oe, 0);

        for (int i = 0; i < 8; i++) begin
            en_b = (i % 2 == 0);
            do_op(vecs[i].op, vecs[i].din, vecs[i].res, vecs[i].c, vecs[i].z);
        end
        en_b = 1'b1;

        // Back-to-back with start held; din changes while busy must not be latched.
        sb_q.push_back('{res: 16'h0002, c: 1'b0, z: 1'b0});
        op = 2'b01;
        din = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        sb_q.push_back('{res: 16'h0003, c: 1'b0, z: 1'b0});
        din = 16'h0002;
        chk("b2b_busy_pch", io_h.busy, 1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done1", io_h.done, 1);
        @(negedge clk);
        chk("b2b_done_pulse", io_h.done, 0);
        chk("b2b_reaccept", io_h.busy, 1);
        din = 16'h0050;
        @(negedge clk);
        chk("b2b_busy_eval", io_h.busy, 1);
        @(negedge clk);
        chk("b2b_done2", io_h.done, 1);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {io_h.done, io_h.busy}, 0);
        chk("b2b_hold_y", io_h.bus_b_y, 16'h0003);

        // Asynchronous reset mid-EVAL aborts the operation with no done pulse.
        op = 2'b01;
        din = 16'h7000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", io_h.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", io_h.result, 0);
        chk("arst_flags", {io_h.carry, io_h.zero, io_h.busy, io_h.done}, 0);
        chk("arst_oe", {io_h.bus_a_oe, io_h.bus_b_oe, io_n.bus_a_oe, io_n.bus_b_oe}, 0);
        chk("arst_y", io_h.bus_a_y, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {io_h.done, io_h.busy, io_h.bus_a_oe}, 0);
        do_op(2'b01, 16'h0010, 16'h0011, 1'b0, 1'b0);

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
